// File: rtl/slot_arb8.sv
// slot_arb8: round-robin owner of one 8-way decoded select; 1 cycle req->gnt, TURN+IDLE dead gap between owners.
// No backpressure, req is a level; optional forced revoke under SLOT_ARB_TIMEOUT_EN.
module slot_arb8 #(
  parameter int MIN_HOLD = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_enl,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [3:0] HOLD_M1 = 4'(MIN_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gnt_q, gnt_d;
  logic       enl_q, enl_d;
  logic [3:0] hold_q, hold_d;
  logic       terr_q, terr_d;
  logic       found;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       to_fire;

  // Scan from the highest offset down so the offset nearest the pointer wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef SLOT_ARB_TIMEOUT_EN
  logic [7:0] to_q, to_d;

  always_comb begin
    to_d = to_q;
    if (state_q != GRANT) begin
      to_d = '0;
    end else if (to_q != 8'hFF) begin
      to_d = to_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  assign to_fire = (state_q == GRANT) && (to_q == 8'(TIMEOUT - 1)) && req[idx_q];
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    enl_d   = enl_q;
    hold_d  = hold_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = pick;
          gnt_d   = 8'd1 << pick;
          enl_d   = 1'b0;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        hold_d = (hold_q == 4'd15) ? hold_q : hold_q + 4'd1;
        if (to_fire) begin
          gnt_d   = '0;
          enl_d   = 1'b1;
          terr_d  = 1'b1;
          state_d = TURN;
        end else if (!req[idx_q] && (hold_q >= HOLD_M1)) begin
          gnt_d   = '0;
          enl_d   = 1'b1;
          state_d = TURN;
        end
      end
      TURN: begin
        ptr_d   = idx_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      enl_q   <= 1'b1;
      hold_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      enl_q   <= enl_d;
      hold_q  <= hold_d;
      terr_q  <= terr_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = idx_q;
  assign gnt_enl     = enl_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_slot_arb8.sv
// Bench for slot_arb8: vector table plus hand sequences, expectations queued at drive time.
module tb_slot_arb8;

  logic       sys_clk = 1'b0;
  logic       resetl;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_enl;
  logic       busy;
  logic       timeout_err;

  always #5 sys_clk = ~sys_clk;

  slot_arb8 #(.MIN_HOLD(2), .TIMEOUT(8)) dut (
    .sys_clk    (sys_clk),
    .resetl     (resetl),
    .req        (req),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_enl    (gnt_enl),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       enl;
    logic       busy;
    logic       terr;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    exp_t       exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  function automatic exp_t mk(input logic [7:0] g, input logic [2:0] i,
                              input logic b, input logic t);
    exp_t e;
    e.gnt  = g;
    e.idx  = i;
    e.enl  = (g == 8'h00);
    e.busy = b;
    e.terr = t;
    return e;
  endfunction

  task automatic cmp(input string name, input exp_t e);
    exp_t a;
    a = {gnt, gnt_idx, gnt_enl, busy, timeout_err};
    checks++;
    if (a === e) begin
      passed++;
    end else begin
      $display("FAIL %s: got gnt=%h idx=%0d enl=%b busy=%b terr=%b, want gnt=%h idx=%0d enl=%b busy=%b terr=%b",
               name, a.gnt, a.idx, a.enl, a.busy, a.terr, e.gnt, e.idx, e.enl, e.busy, e.terr);
    end
  endtask

  task automatic step(input logic [7:0] r, input exp_t e, input string name);
    req = r;
    sb_q.push_back(e);
    @(negedge sys_clk);
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      cmp(name, sb_q.pop_front());
    end
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] i, input logic b);
    vec_t v;
    v.req = r;
    v.exp = mk(g, i, b, 1'b0);
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    req    = 8'h00;
    resetl = 1'b0;
    @(negedge sys_clk);
    resetl = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetl = 1'b0;
    req    = 8'h00;
    repeat (2) @(negedge sys_clk);
    cmp("reset_state", mk(8'h00, 3'd0, 1'b0, 1'b0));
    resetl = 1'b1;

    for (int k = 0; k < 10; k++) add(8'h00, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++)  add(8'h10, 8'h10, 3'd4, 1'b1);
    add(8'h00, 8'h00, 3'd4, 1'b1);
    add(8'h00, 8'h00, 3'd4, 1'b0);
    // pointer is now 5: bit 5 must beat bit 0
    add(8'h21, 8'h20, 3'd5, 1'b1);
    add(8'h01, 8'h20, 3'd5, 1'b1);
    add(8'h01, 8'h00, 3'd5, 1'b1);
    add(8'h01, 8'h00, 3'd5, 1'b0);
    add(8'h01, 8'h01, 3'd0, 1'b1);
    add(8'h00, 8'h01, 3'd0, 1'b1);
    add(8'h00, 8'h00, 3'd0, 1'b1);
    add(8'h00, 8'h00, 3'd0, 1'b0);
    // one-cycle pulse still holds MIN_HOLD=2 cycles
    add(8'h01, 8'h01, 3'd0, 1'b1);
    add(8'h00, 8'h01, 3'd0, 1'b1);
    add(8'h00, 8'h00, 3'd0, 1'b1);
    add(8'h00, 8'h00, 3'd0, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].req, tbl[k].exp, $sformatf("vec%0d", k));
    end

    step(8'h20, mk(8'h20, 3'd5, 1'b1, 1'b0), "rst_mid_grant0");
    step(8'h20, mk(8'h20, 3'd5, 1'b1, 1'b0), "rst_mid_grant1");
    #2 resetl = 1'b0;
    #1 cmp("async_reset", mk(8'h00, 3'd0, 1'b0, 1'b0));
    @(negedge sys_clk);
    resetl = 1'b1;
    step(8'h01, mk(8'h01, 3'd0, 1'b1, 1'b0), "post_reset_grant");
    step(8'h00, mk(8'h01, 3'd0, 1'b1, 1'b0), "post_reset_hold");
    step(8'h00, mk(8'h00, 3'd0, 1'b1, 1'b0), "post_reset_turn");
    step(8'h00, mk(8'h00, 3'd0, 1'b0, 1'b0), "post_reset_idle");

    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [2:0] o;
      logic [7:0] drop;
      o    = 3'(k % 8);
      drop = 8'hFF & ~(8'd1 << o);
      for (int c = 0; c < 3; c++)
        step(8'hFF, mk(8'd1 << o, o, 1'b1, 1'b0), $sformatf("rr%0d_gnt%0d", k, c));
      step(drop,  mk(8'h00, o, 1'b1, 1'b0), $sformatf("rr%0d_turn", k));
      step(8'hFF, mk(8'h00, o, 1'b0, 1'b0), $sformatf("rr%0d_idle", k));
    end

    do_reset();
    step(8'h0C, mk(8'h04, 3'd2, 1'b1, 1'b0), "to_first");
`ifdef SLOT_ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++)
      step(8'h0C, mk(8'h04, 3'd2, 1'b1, 1'b0), $sformatf("to_hold%0d", k));
    step(8'h0C, mk(8'h00, 3'd2, 1'b1, 1'b1), "to_revoke");
    step(8'h0C, mk(8'h00, 3'd2, 1'b0, 1'b0), "to_idle");
    step(8'h0C, mk(8'h08, 3'd3, 1'b1, 1'b0), "to_next_owner");
`else
    for (int k = 0; k < 80; k++)
      step(8'h0C, mk(8'h04, 3'd2, 1'b1, 1'b0), $sformatf("no_to_hold%0d", k));
`endif
    req = 8'h00;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
